gph_sum_resolver: RTL
=====================

Name: gph_sum_resolver

Overview:
- Consumer end of the per-bit generate cells: accepts the WIDTH-bit g/p/h vectors the cells produce, resolves carries through a prefix network and emits sum, carry-out and signed overflow.
- Two-stage valid/ready pipeline that sits between the generate-cell array and the adder output register of the 6-bit adder datapath.
- Also checks every accepted input for illegal g/p/h codes.

Parameters:
- WIDTH, 6, operand width in bits (legal range 2..16).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a g/p/h/cin beat.
- in_ready  out  1  block accepts a beat this cycle.
- g  in  WIDTH  per-bit generate (x AND y).
- p  in  WIDTH  per-bit propagate (x OR y).
- h  in  WIDTH  per-bit half-sum (x XOR y).
- cin  in  1  carry-in.
- out_valid  out  1  result beat available.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  resolved sum.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow, c[WIDTH] XOR c[WIDTH-1].
- err  out  1  sticky flag for an illegal g/p/h code.

Behaviour:
- Reset (async assert, sync-released by the clock edge): s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0, ovf=0, err=0. in_ready=1 once reset deasserts.
- Transfer occurs on a rising edge with valid=1 and ready=1 on the same interface.
- Stage 1, on input accept:
  - Register h and cin.
  - Register the carry vector c[1..WIDTH], where c[0]=cin and c[i+1]=g[i] OR (p[i] AND c[i]).
  - Compute the carries with a log-depth prefix network, not a ripple chain.
- Stage 2: register sum[i]=h[i] XOR c[i], cout=c[WIDTH], ovf=c[WIDTH] XOR c[WIDTH-1].
- Latency: 2 cycles from the input accept to out_valid, when out_ready is held 1.
- Throughput: one beat per cycle.
- Pipeline flow control:
  - s2 loads when s1_valid AND (NOT s2_valid OR out_ready).
  - s1 loads when in_valid AND in_ready.
  - in_ready = NOT s1_valid OR (s1 advances this cycle).
  - in_ready is combinational from out_ready. No skid buffer.
- Bubbles collapse: an empty s2 takes s1 regardless of out_ready.
- While out_valid=1 and out_ready=0, sum, cout and ovf stay stable.
- With both stages full and out_ready=0, in_ready=0. No beat is lost or duplicated.
- Simultaneous s2 drain and s1 refill in the same cycle is legal and must not stall.
- Legal per-bit codes for {g,p,h} are 000, 011 and 110. Any other code on an accepted beat sets err=1 on the next edge.
- err stays set until reset. The offending beat is still processed normally.
- Inputs are ignored when in_valid=0. err is not evaluated on non-accepted cycles.
- Reset mid-operation: all in-flight beats are discarded and outputs return to reset values asynchronously.

Decomposition:
- Package adder_pkg:
  - WIDTH_DEFAULT=6.
  - Legal code constants GPH_ZERO=3'b000, GPH_PROP=3'b011, GPH_GEN=3'b110.
  - Function gph_legal(g,p,h).
- Sub-module prefix_carry_net: combinational Kogge-Stone (g,p,cin) -> c[WIDTH:1], parameterised by WIDTH.
- gph_sum_resolver holds the two pipeline registers, the handshake logic and the err check.

Test Plan:
- Single beat, out_ready=1: x=21 and y=14 give g=000100, p=011111, h=011011, cin=0. Required: 2 cycles later sum=100011 (35), cout=0, ovf=1, err=0.
- Wrap-around: x=63 and y=1 give g=000001, p=111111, h=111110, cin=0. Required: sum=000000, cout=1, ovf=0.
- Carry-in: g=0, p=111111, h=111111, cin=1. Required: sum=000000, cout=1, ovf=0.
- Backpressure:
  - Stimulus: stream beats A, B, C back-to-back while out_ready=0 for 4 cycles.
  - Required: in_ready falls after A and B fill the pipe. A is held stable on sum.
  - Required: on release, A, B, C emerge in order on consecutive cycles, with no loss or duplication.
- Illegal code: bit0 {g,p,h}=100 on an accepted beat. Required: err=1 on the next edge and sticky through 10 more legal beats. A beat with the same code while in_valid=0 does not set err.
- Reset mid-flight: assert rst_n=0 with both stages valid. Required: out_valid=0, sum=0 and err=0 immediately. After deassert, the first accepted beat appears 2 cycles later, correct.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the g/p/h adder datapath.
package adder_pkg;

  localparam int WIDTH_DEFAULT = 6;

  // Only these {g,p,h} codes can come from a real x/y bit pair.
  localparam logic [2:0] GPH_ZERO = 3'b000;  // x=0, y=0
  localparam logic [2:0] GPH_PROP = 3'b011;  // exactly one of x, y set
  localparam logic [2:0] GPH_GEN  = 3'b110;  // x=1, y=1

  function automatic logic gph_legal(input logic g, input logic p, input logic h);
    logic [2:0] code;
    code = {g, p, h};
    return (code == GPH_ZERO) || (code == GPH_PROP) || (code == GPH_GEN);
  endfunction

endpackage

// File: rtl/prefix_carry_net.sv
// Kogge-Stone carry network: (g, p, cin) -> c[WIDTH:1] in log2(WIDTH) levels.
// p is the OR-propagate; it is still correct for carry resolution.
module prefix_carry_net
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic             cin,
  output logic [WIDTH:1]   c
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // gl[k][i] / pl[k][i]: group generate/propagate over bits [i : i-2^k+1]
  logic [LEVELS:0][WIDTH-1:0] gl;
  logic [LEVELS:0][WIDTH-1:0] pl;

  assign gl[0] = g;
  assign pl[0] = p;

  for (genvar lv = 0; lv < LEVELS; lv++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << lv)) begin : g_cmb
        assign gl[lv+1][i] = gl[lv][i] | (pl[lv][i] & gl[lv][i-(1<<lv)]);
        assign pl[lv+1][i] = pl[lv][i] & pl[lv][i-(1<<lv)];
      end else begin : g_pass
        assign gl[lv+1][i] = gl[lv][i];
        assign pl[lv+1][i] = pl[lv][i];
      end
    end
  end

  // After the last level every group spans [i:0]; fold cin in once at the end.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cout
    assign c[i+1] = gl[LEVELS][i] | (pl[LEVELS][i] & cin);
  end

endmodule

// File: rtl/gph_sum_resolver.sv
// Two-stage valid/ready pipeline: carries resolved in s1, sum/cout/ovf in s2.
// Also flags (sticky) any illegal {g,p,h} code on an accepted beat.
module gph_sum_resolver
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] h,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             err
);

  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe;
  logic            s1_load;
  logic            s2_load;
  logic [WIDTH-1:0] h_s1;
  logic             cin_s1;
  logic [WIDTH:1]   c_s1;
  logic [WIDTH:1]   c_nxt;
  logic [WIDTH:0]   c_full;
  logic             illegal;

  prefix_carry_net #(.WIDTH(WIDTH)) u_pcn (
    .g   (g),
    .p   (p),
    .cin (cin),
    .c   (c_nxt)
  );

  // Handshake: empty s2 always takes s1; in_ready follows out_ready combinationally.
  always_comb begin
    s2_load  = vld_pipe[1] & (~vld_pipe[2] | out_ready);
    in_ready = ~vld_pipe[1] | s2_load;
    s1_load  = in_valid & in_ready;
  end

  // Any bit with a code outside {000, 011, 110} is illegal.
  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!gph_legal(g[i], p[i], h[i])) illegal = 1'b1;
    end
  end

  // Stage valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_load)      vld_pipe[1] <= 1'b1;
      else if (s2_load) vld_pipe[1] <= 1'b0;
      if (s2_load)        vld_pipe[2] <= 1'b1;
      else if (out_ready) vld_pipe[2] <= 1'b0;
    end
  end

  // Stage 1: carries plus the operands still needed for the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_s1   <= '0;
      cin_s1 <= 1'b0;
      c_s1   <= '0;
    end else if (s1_load) begin
      h_s1   <= h;
      cin_s1 <= cin;
      c_s1   <= c_nxt;
    end
  end

  assign c_full = {c_s1, cin_s1};

  // Stage 2: result register, held while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (s2_load) begin
      sum  <= h_s1 ^ c_full[WIDTH-1:0];
      cout <= c_full[WIDTH];
      ovf  <= c_full[WIDTH] ^ c_full[WIDTH-1];
    end
  end

  // Sticky error, evaluated only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  err <= 1'b0;
    else if (s1_load && illegal) err <= 1'b1;
  end

  assign out_valid = vld_pipe[2];

endmodule
